router_ingress_ctrl: RTL

Packet ingress controller for the 1x3 router, sitting directly upstream of the three 16x9 output FIFOs. It accepts the byte stream from the source, decodes the header, and steers header, payload and parity bytes into the addressed FIFO with the header-marker bit (`lfd_state`). It throttles the source with `busy` when the destination FIFO is full or still draining, and checks packet parity.

---
 rtl/router_pkg.sv | 41 ++++
 rtl/router_parity_acc.sv | 26 ++
 rtl/router_ingress_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and header field helpers for the 1x3 router ingress path.
package router_pkg;

    localparam int NUM_PORTS = 3;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EMPTY,
        ST_HDR,
        ST_DATA,
        ST_PARITY,
        ST_CHECK,
        ST_DROP
    } ingress_state_e;

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

    // The invalid address decodes to no port at all, so it can never raise a write.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            oh[i] = (addr == 2'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes, with a live compare against a candidate parity byte.
module router_parity_acc (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic [7:0] cmp_byte,
    output logic       match
);

    logic [7:0] acc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= data;
        end else if (enable) begin
            acc_q <= acc_q ^ data;
        end
    end

    assign match = (acc_q == cmp_byte);

endmodule

// File: rtl/router_ingress_ctrl.sv
// Ingress controller: decodes the packet header, steers bytes into the addressed FIFO
// and checks the trailing parity byte.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | waiting for a header byte, source free to send
// WAIT_EMPTY  | header latched, holding source until destination FIFO drains
// HDR         | writing the latched header with lfd_state marker
// DATA        | forwarding payload bytes, counting up to the header length
// PARITY      | forwarding the parity byte and capturing the compare result
// CHECK       | publishing parity result, source held for one cycle
// DROP        | invalid address, absorbing bytes until pkt_valid drops
module router_ingress_ctrl #(
    parameter int NUM_PORTS = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 lfd_state,
    output logic [7:0]           dout,
    output logic                 err,
    output logic                 parity_done
);

    import router_pkg::*;

    ingress_state_e state, next_state;

    logic [7:0]           hdr_q;
    logic [5:0]           count_q;
    logic                 mismatch_q;
    logic [1:0]           addr_q;
    logic [5:0]           len_q;
    logic [NUM_PORTS-1:0] dest_oh;
    logic                 full_sel;
    logic                 empty_sel;
    logic                 hdr_empty;

    logic hdr_load;
    logic acc_load;
    logic acc_en;
    logic cnt_inc;
    logic par_take;
    logic acc_match;

    assign addr_q    = hdr_addr(hdr_q);
    assign len_q     = hdr_len(hdr_q);
    assign dest_oh   = port_onehot(addr_q);
    assign full_sel  = |(fifo_full & dest_oh);
    assign empty_sel = |(fifo_empty & dest_oh);
    assign hdr_empty = |(fifo_empty & port_onehot(hdr_addr(data_in)));

    router_parity_acc u_parity_acc (
        .clock    (clock),
        .reset    (reset),
        .load     (acc_load),
        .enable   (acc_en),
        .data     (data_in),
        .cmp_byte (data_in),
        .match    (acc_match)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        write_enb  = '0;
        lfd_state  = 1'b0;
        dout       = '0;
        hdr_load   = 1'b0;
        acc_load   = 1'b0;
        acc_en     = 1'b0;
        cnt_inc    = 1'b0;
        par_take   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pkt_valid) begin
                    hdr_load = 1'b1;
                    acc_load = 1'b1;
                    if (hdr_addr(data_in) == ADDR_INVALID) begin
                        next_state = ST_DROP;
                    end else if (hdr_empty) begin
                        next_state = ST_HDR;
                    end else begin
                        next_state = ST_WAIT_EMPTY;
                    end
                end
            end

            ST_WAIT_EMPTY: begin
                busy = 1'b1;
                if (empty_sel) begin
                    next_state = ST_HDR;
                end
            end

            ST_HDR: begin
                busy       = 1'b1;
                write_enb  = dest_oh;
                lfd_state  = 1'b1;
                dout       = hdr_q;
                next_state = (len_q != 6'd0) ? ST_DATA : ST_PARITY;
            end

            // Full is sampled in the same cycle as the write, so a full FIFO
            // simply turns the cycle into a stall.
            ST_DATA: begin
                busy = full_sel;
                if (pkt_valid && !full_sel) begin
                    write_enb = dest_oh;
                    dout      = data_in;
                    acc_en    = 1'b1;
                    cnt_inc   = 1'b1;
                    if ((count_q + 6'd1) == len_q) begin
                        next_state = ST_PARITY;
                    end
                end
            end

            ST_PARITY: begin
                busy = full_sel;
                if (pkt_valid && !full_sel) begin
                    write_enb  = dest_oh;
                    dout       = data_in;
                    par_take   = 1'b1;
                    next_state = ST_CHECK;
                end
            end

            ST_CHECK: begin
                busy       = 1'b1;
                next_state = ST_IDLE;
            end

            ST_DROP: begin
                if (!pkt_valid) begin
                    next_state = ST_IDLE;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hdr_q       <= '0;
            count_q     <= '0;
            mismatch_q  <= 1'b0;
            err         <= 1'b0;
            parity_done <= 1'b0;
        end else begin
            if (hdr_load) begin
                hdr_q   <= data_in;
                count_q <= '0;
            end else if (cnt_inc) begin
                count_q <= count_q + 6'd1;
            end

            if (par_take) begin
                mismatch_q <= ~acc_match;
            end

            // parity_done is high for exactly the CHECK cycle; err follows at its end.
            parity_done <= par_take;

            if (state == ST_CHECK) begin
                err <= mismatch_q;
            end
        end
    end

endmodule
